// File: rtl/matrix_slot_allocator_pkg.sv
// Shared sizing, FSM states and slot-table types for the matrix slot allocator.
// Slot k lives at base address k*SLOT_WORDS; matrix ID is slot index + 1.
package matrix_pkg;

    localparam int NUM_SLOTS   = 16;
    localparam int MAX_DIM     = 5;
    localparam int SLOT_WORDS  = MAX_DIM * MAX_DIM;
    localparam int PER_DIM_MAX = 2;
    localparam int ADDR_W      = 9;
    localparam int SEQ_W       = 8;
    localparam int IDX_W       = $clog2(NUM_SLOTS);
    localparam int CNT_W       = $clog2(NUM_SLOTS + 1);
    localparam int ID_W        = 5;
    localparam int DIM_W       = 3;

    localparam logic [DIM_W-1:0] MAX_DIM_V = DIM_W'(MAX_DIM);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SCAN        = 2'd1,
        ST_GRANT       = 2'd2,
        ST_WAIT_COMMIT = 2'd3
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             pending;
        logic [DIM_W-1:0] m;
        logic [DIM_W-1:0] n;
        logic [SEQ_W-1:0] stamp;
    } slot_t;

    typedef struct packed {
        logic [CNT_W-1:0] same_cnt;
        logic             same_found;
        logic [IDX_W-1:0] same_idx;
        logic [SEQ_W-1:0] same_age;
        logic             free_found;
        logic [IDX_W-1:0] free_idx;
        logic             glob_found;
        logic [IDX_W-1:0] glob_idx;
        logic [SEQ_W-1:0] glob_age;
    } scan_acc_t;

    function automatic logic dims_legal(input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] n);
        return (m != '0) && (m <= MAX_DIM_V) && (n != '0) && (n <= MAX_DIM_V);
    endfunction

    function automatic logic [ADDR_W-1:0] slot_base(input logic [IDX_W-1:0] idx);
        return ADDR_W'(idx) * ADDR_W'(SLOT_WORDS);
    endfunction

endpackage

// File: rtl/matrix_slot_allocator_if.sv
// Request/grant, commit/abort and ID-lookup signals between the matrix input path and the allocator.
// master = requester side, slave = allocator side.
interface matrix_slot_allocator_if;
    import matrix_pkg::*;

    logic              alloc_req;
    logic [DIM_W-1:0]  alloc_m;
    logic [DIM_W-1:0]  alloc_n;
    logic [ADDR_W-1:0] alloc_base;
    logic              alloc_ready;
    logic [ID_W-1:0]   alloc_id;
    logic              alloc_err;
    logic              commit;
    logic              abort;
    logic              lookup_req;
    logic [ID_W-1:0]   lookup_id;
    logic              lookup_valid;
    logic              lookup_hit;
    logic [ADDR_W-1:0] lookup_base;
    logic [DIM_W-1:0]  lookup_m;
    logic [DIM_W-1:0]  lookup_n;
    logic              busy;

    modport master (
        output alloc_req, alloc_m, alloc_n, commit, abort, lookup_req, lookup_id,
        input  alloc_base, alloc_ready, alloc_id, alloc_err,
        input  lookup_valid, lookup_hit, lookup_base, lookup_m, lookup_n, busy
    );

    modport slave (
        input  alloc_req, alloc_m, alloc_n, commit, abort, lookup_req, lookup_id,
        output alloc_base, alloc_ready, alloc_id, alloc_err,
        output lookup_valid, lookup_hit, lookup_base, lookup_m, lookup_n, busy
    );

endinterface

// File: rtl/matrix_slot_allocator_scan.sv
// Walks the slot table one entry per cycle and picks the victim slot for the pending request.
// Accumulators restart whenever idx is 0; the victim is registered on the last slot (MSA_EVICT_STATS_EN adds victim_valid).
module msa_scan_unit
    import matrix_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [IDX_W-1:0] idx,
    input  slot_t            entry,
    input  logic [DIM_W-1:0] req_m,
    input  logic [DIM_W-1:0] req_n,
    input  logic [SEQ_W-1:0] seq,
    output logic [IDX_W-1:0] victim
`ifdef MSA_EVICT_STATS_EN
    ,
    output logic             victim_valid
`endif
);

    scan_acc_t        acc_q, acc_d, acc_nxt;
    logic [SEQ_W-1:0] age;
    logic [IDX_W-1:0] victim_q, victim_d;
    logic             victim_valid_q, victim_valid_d;

    always_comb begin
        acc_nxt        = (idx == '0) ? '0 : acc_q;
        age            = seq - entry.stamp;
        victim_d       = victim_q;
        victim_valid_d = victim_valid_q;

        if (entry.valid) begin
            if (entry.m == req_m && entry.n == req_n) begin
                acc_nxt.same_cnt = acc_nxt.same_cnt + CNT_W'(1);
                // strict compare keeps the lower index on equal ages
                if (!acc_nxt.same_found || age > acc_nxt.same_age) begin
                    acc_nxt.same_found = 1'b1;
                    acc_nxt.same_idx   = idx;
                    acc_nxt.same_age   = age;
                end
            end
            if (!acc_nxt.glob_found || age > acc_nxt.glob_age) begin
                acc_nxt.glob_found = 1'b1;
                acc_nxt.glob_idx   = idx;
                acc_nxt.glob_age   = age;
            end
        end else if (!entry.pending && !acc_nxt.free_found) begin
            acc_nxt.free_found = 1'b1;
            acc_nxt.free_idx   = idx;
        end

        acc_d = step ? acc_nxt : acc_q;

        if (step && idx == IDX_W'(NUM_SLOTS - 1)) begin
            if (acc_nxt.same_cnt >= CNT_W'(PER_DIM_MAX)) begin
                victim_d       = acc_nxt.same_idx;
                victim_valid_d = 1'b1;
            end else if (acc_nxt.free_found) begin
                victim_d       = acc_nxt.free_idx;
                victim_valid_d = 1'b0;
            end else begin
                victim_d       = acc_nxt.glob_idx;
                victim_valid_d = acc_nxt.glob_found;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q          <= '0;
            victim_q       <= '0;
            victim_valid_q <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            victim_q       <= victim_d;
            victim_valid_q <= victim_valid_d;
        end
    end

    assign victim = victim_q;
`ifdef MSA_EVICT_STATS_EN
    assign victim_valid = victim_valid_q;
`endif

endmodule

// File: rtl/matrix_slot_allocator.sv
// Matrix storage slot allocator: scan/grant/commit FSM, slot table and ID lookup; grant 17 cycles after request.
// No backpressure: lookups answer the next cycle in any state. MSA_EVICT_STATS_EN adds the evict_count port.
module matrix_slot_allocator
    import matrix_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    matrix_slot_allocator_if.slave   bus
`ifdef MSA_EVICT_STATS_EN
    ,
    output logic [15:0]              evict_count
`endif
);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic [DIM_W-1:0]  req_m_q, req_m_d, req_n_q, req_n_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
    slot_t             slots_q [NUM_SLOTS];
    slot_t             slots_d [NUM_SLOTS];
    logic [ADDR_W-1:0] alloc_base_q, alloc_base_d;
    logic [ID_W-1:0]   alloc_id_q, alloc_id_d;
    logic              alloc_ready_q, alloc_ready_d;
    logic              alloc_err_q, alloc_err_d;
    logic              lookup_valid_q, lookup_valid_d;
    logic              lookup_hit_q, lookup_hit_d;
    logic [ADDR_W-1:0] lookup_base_q, lookup_base_d;
    logic [DIM_W-1:0]  lookup_m_q, lookup_m_d, lookup_n_q, lookup_n_d;
    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  victim;
`ifdef MSA_EVICT_STATS_EN
    logic              victim_valid;
    logic [15:0]       evict_q, evict_d;
`endif

    msa_scan_unit u_scan (
        .clk          (clk),
        .rst          (rst),
        .step         (state_q == ST_SCAN),
        .idx          (scan_idx_q),
        .entry        (slots_q[scan_idx_q]),
        .req_m        (req_m_q),
        .req_n        (req_n_q),
        .seq          (seq_q),
        .victim       (victim)
`ifdef MSA_EVICT_STATS_EN
        ,
        .victim_valid (victim_valid)
`endif
    );

    always_comb begin
        state_d        = state_q;
        scan_idx_d     = scan_idx_q;
        req_m_d        = req_m_q;
        req_n_d        = req_n_q;
        seq_d          = seq_q;
        pend_idx_d     = pend_idx_q;
        slots_d        = slots_q;
        alloc_base_d   = alloc_base_q;
        alloc_id_d     = alloc_id_q;
        alloc_ready_d  = 1'b0;
        alloc_err_d    = 1'b0;
        lookup_valid_d = 1'b0;
        lookup_hit_d   = lookup_hit_q;
        lookup_base_d  = lookup_base_q;
        lookup_m_d     = lookup_m_q;
        lookup_n_d     = lookup_n_q;
        lk_idx         = IDX_W'(bus.lookup_id - ID_W'(1));
`ifdef MSA_EVICT_STATS_EN
        evict_d        = evict_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.alloc_req) begin
                    if (dims_legal(bus.alloc_m, bus.alloc_n)) begin
                        req_m_d    = bus.alloc_m;
                        req_n_d    = bus.alloc_n;
                        scan_idx_d = '0;
                        state_d    = ST_SCAN;
                    end else begin
                        alloc_err_d = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                scan_idx_d = scan_idx_q + IDX_W'(1);
                if (scan_idx_q == IDX_W'(NUM_SLOTS - 1)) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                slots_d[victim].valid   = 1'b0;
                slots_d[victim].pending = 1'b1;
                pend_idx_d    = victim;
                alloc_base_d  = slot_base(victim);
                alloc_id_d    = ID_W'(victim) + ID_W'(1);
                alloc_ready_d = 1'b1;
                state_d       = ST_WAIT_COMMIT;
`ifdef MSA_EVICT_STATS_EN
                if (victim_valid && evict_q != 16'hFFFF) begin
                    evict_d = evict_q + 16'd1;
                end
`endif
            end
            ST_WAIT_COMMIT: begin
                // a fresh request here also finalises the matrix just written
                if (bus.commit || bus.alloc_req) begin
                    slots_d[pend_idx_q].valid   = 1'b1;
                    slots_d[pend_idx_q].pending = 1'b0;
                    slots_d[pend_idx_q].m       = req_m_q;
                    slots_d[pend_idx_q].n       = req_n_q;
                    slots_d[pend_idx_q].stamp   = seq_q;
                    seq_d   = seq_q + SEQ_W'(1);
                    state_d = ST_IDLE;
                    if (bus.alloc_req) begin
                        if (dims_legal(bus.alloc_m, bus.alloc_n)) begin
                            req_m_d    = bus.alloc_m;
                            req_n_d    = bus.alloc_n;
                            scan_idx_d = '0;
                            state_d    = ST_SCAN;
                        end else begin
                            alloc_err_d = 1'b1;
                        end
                    end
                end else if (bus.abort) begin
                    slots_d[pend_idx_q].pending = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // reads the pre-update table, so a same-cycle commit is not visible
        if (bus.lookup_req) begin
            lookup_valid_d = 1'b1;
            if (bus.lookup_id != '0 && bus.lookup_id <= ID_W'(NUM_SLOTS) &&
                slots_q[lk_idx].valid && !slots_q[lk_idx].pending) begin
                lookup_hit_d  = 1'b1;
                lookup_base_d = slot_base(lk_idx);
                lookup_m_d    = slots_q[lk_idx].m;
                lookup_n_d    = slots_q[lk_idx].n;
            end else begin
                lookup_hit_d  = 1'b0;
                lookup_base_d = '0;
                lookup_m_d    = '0;
                lookup_n_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            scan_idx_q     <= '0;
            req_m_q        <= '0;
            req_n_q        <= '0;
            seq_q          <= '0;
            pend_idx_q     <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) slots_q[i] <= '0;
            alloc_base_q   <= '0;
            alloc_id_q     <= '0;
            alloc_ready_q  <= 1'b0;
            alloc_err_q    <= 1'b0;
            lookup_valid_q <= 1'b0;
            lookup_hit_q   <= 1'b0;
            lookup_base_q  <= '0;
            lookup_m_q     <= '0;
            lookup_n_q     <= '0;
`ifdef MSA_EVICT_STATS_EN
            evict_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            scan_idx_q     <= scan_idx_d;
            req_m_q        <= req_m_d;
            req_n_q        <= req_n_d;
            seq_q          <= seq_d;
            pend_idx_q     <= pend_idx_d;
            slots_q        <= slots_d;
            alloc_base_q   <= alloc_base_d;
            alloc_id_q     <= alloc_id_d;
            alloc_ready_q  <= alloc_ready_d;
            alloc_err_q    <= alloc_err_d;
            lookup_valid_q <= lookup_valid_d;
            lookup_hit_q   <= lookup_hit_d;
            lookup_base_q  <= lookup_base_d;
            lookup_m_q     <= lookup_m_d;
            lookup_n_q     <= lookup_n_d;
`ifdef MSA_EVICT_STATS_EN
            evict_q        <= evict_d;
`endif
        end
    end

    assign bus.alloc_base   = alloc_base_q;
    assign bus.alloc_ready  = alloc_ready_q;
    assign bus.alloc_id     = alloc_id_q;
    assign bus.alloc_err    = alloc_err_q;
    assign bus.lookup_valid = lookup_valid_q;
    assign bus.lookup_hit   = lookup_hit_q;
    assign bus.lookup_base  = lookup_base_q;
    assign bus.lookup_m     = lookup_m_q;
    assign bus.lookup_n     = lookup_n_q;
    assign bus.busy         = (state_q != ST_IDLE);
`ifdef MSA_EVICT_STATS_EN
    assign evict_count      = evict_q;
`endif

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Directed and randomized bench for matrix_slot_allocator against a slot-table reference model.
// Build with MSA_EVICT_STATS_EN defined to also check evict_count.
module tb_matrix_slot_allocator;
    import matrix_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matrix_slot_allocator_if bus();
`ifdef MSA_EVICT_STATS_EN
    logic [15:0] evict_count;
`endif

    matrix_slot_allocator dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef MSA_EVICT_STATS_EN
        ,
        .evict_count (evict_count)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    // reference model: committed matrices, their dims and commit stamps
    bit         mv   [16];
    int         mm   [16];
    int         mn   [16];
    logic [7:0] mst  [16];
    logic [7:0] mseq;
    bit         mpend;
    int         mpidx, mpm, mpn;
    int         mevict;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mv[i] = 0; mm[i] = 0; mn[i] = 0; mst[i] = 8'd0;
        end
        mseq = 8'd0; mpend = 0; mpidx = 0; mevict = 0;
    endtask

    task automatic model_commit();
        if (mpend) begin
            mv[mpidx] = 1; mm[mpidx] = mpm; mn[mpidx] = mpn; mst[mpidx] = mseq;
            mseq = mseq + 8'd1;
            mpend = 0;
        end
    endtask

    function automatic int age_of(input int i);
        logic [7:0] a;
        a = mseq - mst[i];
        return int'(a);
    endfunction

    // Oldest among the slots selected by 'same' (or all valid), lowest index on ties.
    function automatic int oldest(input bit only_same, input int m, input int n);
        int best = -1;
        for (int i = 0; i < 16; i++) begin
            if (mv[i] && (!only_same || (mm[i] == m && mn[i] == n))) begin
                if (best < 0 || age_of(i) > age_of(best)) best = i;
            end
        end
        return best;
    endfunction

    task automatic model_victim(input int m, input int n, output int v, output bit was_valid);
        int cnt = 0;
        int free_slot = -1;
        for (int i = 0; i < 16; i++) begin
            if (mv[i] && mm[i] == m && mn[i] == n) cnt++;
            if (!mv[i] && free_slot < 0) free_slot = i;
        end
        if (cnt >= PER_DIM_MAX) begin
            v = oldest(1, m, n); was_valid = 1;
        end else if (free_slot >= 0) begin
            v = free_slot; was_valid = 0;
        end else begin
            v = oldest(0, m, n); was_valid = 1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic do_alloc(input int m, input int n);
        int  v, lat;
        bit  wv;
        model_commit();
        model_victim(m, n, v, wv);
        bus.alloc_req = 1'b1; bus.alloc_m = 3'(m); bus.alloc_n = 3'(n);
        tick();
        bus.alloc_req = 1'b0;
        check("busy_scan", bus.busy, 1);
        lat = 0;
        while (bus.alloc_ready !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("alloc_latency", lat, NUM_SLOTS + 1);
        check("alloc_base", bus.alloc_base, v * SLOT_WORDS);
        check("alloc_id", bus.alloc_id, v + 1);
        mv[v] = 0; mpend = 1; mpidx = v; mpm = m; mpn = n;
        if (wv && mevict < 16'hFFFF) mevict++;
`ifdef MSA_EVICT_STATS_EN
        check("evict_count", evict_count, mevict);
`endif
        tick();
        check("alloc_ready_pulse", bus.alloc_ready, 0);
    endtask

    task automatic do_finish(input bit c, input bit a);
        bus.commit = c; bus.abort = a;
        tick();
        bus.commit = 1'b0; bus.abort = 1'b0;
        if (c) model_commit();
        else if (a) mpend = 0;
        check("busy_after_finish", bus.busy, 0);
    endtask

    task automatic do_lookup(input int id);
        bit hit;
        hit = (id >= 1 && id <= 16) ? mv[id - 1] : 1'b0;
        bus.lookup_req = 1'b1; bus.lookup_id = 5'(id);
        tick();
        bus.lookup_req = 1'b0;
        check("lookup_valid", bus.lookup_valid, 1);
        check("lookup_hit", bus.lookup_hit, hit);
        check("lookup_base", bus.lookup_base, hit ? (id - 1) * SLOT_WORDS : 0);
        check("lookup_m", bus.lookup_m, hit ? mm[id - 1] : 0);
        check("lookup_n", bus.lookup_n, hit ? mn[id - 1] : 0);
    endtask

    initial begin
        int seen, r;
        bus.alloc_req = 1'b0; bus.alloc_m = '0; bus.alloc_n = '0;
        bus.commit = 1'b0; bus.abort = 1'b0;
        bus.lookup_req = 1'b0; bus.lookup_id = '0;
        do_reset();

        check("rst_busy", bus.busy, 0);
        check("rst_alloc_ready", bus.alloc_ready, 0);
        check("rst_alloc_base", bus.alloc_base, 0);
        check("rst_lookup_valid", bus.lookup_valid, 0);

        // first allocation and lookup
        do_alloc(2, 3);
        do_finish(1, 0);
        do_lookup(1);

        // third 2x3 evicts the oldest 2x3, slot 0
        do_alloc(2, 3); do_finish(1, 0);
        do_alloc(2, 3);
        check("third_2x3_base", bus.alloc_base, 0);
        do_finish(1, 0);
        do_lookup(1); do_lookup(2); do_lookup(3);

        // full table, new dims -> global oldest
        do_reset();
        for (int k = 0; k < 16; k++) begin
            do_alloc(1 + k % 5, 1 + k / 5);
            do_finish(1, 0);
        end
        do_alloc(4, 4);
        check("full_victim_base", bus.alloc_base, 0);
        do_finish(1, 0);
        do_lookup(1); do_lookup(16);

        // illegal dims
        do_reset();
        bus.alloc_req = 1'b1; bus.alloc_m = 3'd0; bus.alloc_n = 3'd3;
        tick();
        bus.alloc_req = 1'b0;
        check("err_pulse", bus.alloc_err, 1);
        check("err_busy", bus.busy, 0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.alloc_ready === 1'b1 || bus.alloc_err === 1'b1 || bus.busy === 1'b1) seen++;
        end
        check("err_quiet_after", seen, 0);

        // abort, and a pending slot is never a hit
        do_alloc(3, 3);
        do_lookup(1);
        do_finish(0, 1);
        do_lookup(1);
        do_alloc(3, 3);
        check("after_abort_base", bus.alloc_base, 0);
        do_finish(1, 0);

        // request while waiting commits the pending slot
        do_reset();
        do_alloc(1, 1);
        do_alloc(1, 1);
        check("implicit_commit_base", bus.alloc_base, 25);
        do_lookup(1);
        do_finish(1, 0);

        // reset in the middle of a scan
        bus.alloc_req = 1'b1; bus.alloc_m = 3'd2; bus.alloc_n = 3'd2;
        tick();
        bus.alloc_req = 1'b0;
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        model_reset();
        check("midscan_busy", bus.busy, 0);
        check("midscan_alloc_base", bus.alloc_base, 0);
        check("midscan_alloc_id", bus.alloc_id, 0);
        check("midscan_lookup_hit", bus.lookup_hit, 0);
`ifdef MSA_EVICT_STATS_EN
        check("midscan_evict", evict_count, 0);
`endif
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.alloc_ready === 1'b1) seen++;
        end
        check("midscan_no_grant", seen, 0);

        // random traffic, long enough to wrap the commit sequence
        for (int it = 0; it < 320; it++) begin
            do_alloc($urandom_range(1, 3), $urandom_range(1, 3));
            r = $urandom_range(0, 9);
            if (r == 0)      do_finish(0, 1);
            else if (r == 1) do_finish(1, 1);
            else if (r != 2) do_finish(1, 0);
            do_lookup($urandom_range(0, 17));
        end
        if (mpend) do_finish(1, 0);
        for (int id = 1; id <= 16; id++) do_lookup(id);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
